sweep_ctrl8b: RTL and testbench

//  Sequencer for counter8b_updown, which has no enable or load. Drives the counter's dir and reset so its count

---
 rtl/sweep_ctrl8b.sv | 176 +++++++++++++++++
 tb/tb_sweep_ctrl8b.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl8b.sv
// Sequencer for a free-running up/down counter: steers dir/reset so the count traces
// lo->hi->lo triangles for n sweeps, then parks it at 0, faulting on any divergence.
module sweep_ctrl8b #(
   parameter int WIDTH   = 8,
   parameter int SWEEP_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   input  logic [SWEEP_W-1:0] n_sweeps,
   input  logic [WIDTH-1:0]   cnt_value,
   output logic               cnt_rst,
   output logic               cnt_dir,
   output logic               busy,
   output logic [SWEEP_W-1:0] sweep_cnt,
   output logic               done,
   output logic               aborted,
   output logic               cfg_err,
   output logic               fault
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      UP   = 2'd2,
      DOWN = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(32'd1);
   localparam logic [WIDTH:0]     TWO_X = (WIDTH+1)'(32'd2);
   localparam logic [SWEEP_W-1:0] ONE_S = SWEEP_W'(32'd1);

   state_t             state_r, state_s;
   logic [WIDTH-1:0]   lo_r, hi_r, exp_r, lo_s, hi_s, exp_s;
   logic [SWEEP_W-1:0] n_r, n_s, sweep_s, sweep_inc_s;
   logic               rst_s, dir_s, done_s, aborted_s, cfg_err_s, fault_s, cfg_ok_s;

   // Next-state and next-output logic; stop and fault override the per-state decisions.
   always_comb begin
      state_s     = state_r;
      lo_s        = lo_r;
      hi_s        = hi_r;
      n_s         = n_r;
      exp_s       = exp_r;
      sweep_s     = sweep_cnt;
      rst_s       = cnt_rst;
      dir_s       = cnt_dir;
      done_s      = 1'b0;
      aborted_s   = 1'b0;
      cfg_err_s   = 1'b0;
      fault_s     = fault;
      sweep_inc_s = sweep_cnt + ONE_S;
      // Compare one bit wider so lo+2 cannot wrap past hi.
      cfg_ok_s    = ({1'b0, hi} >= ({1'b0, lo} + TWO_X)) && (n_sweeps != '0);

      case (state_r)
         IDLE: begin
            rst_s = 1'b1;
            dir_s = 1'b1;
            if (start) begin
               if (cfg_ok_s) begin
                  lo_s    = lo;
                  hi_s    = hi;
                  n_s     = n_sweeps;
                  exp_s   = '0;
                  sweep_s = '0;
                  fault_s = 1'b0;
                  rst_s   = 1'b0;
                  state_s = (lo == '0) ? UP : SEEK;
               end else begin
                  cfg_err_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SEEK: begin
            if (cnt_value == lo_r - ONE_W) begin
               state_s = UP;
            end else begin
               state_s = SEEK;
            end
         end
         UP: begin
            // Turn one count early so the registered dir lands the peak on hi.
            if (cnt_value == hi_r - ONE_W) begin
               dir_s   = 1'b0;
               state_s = DOWN;
            end else begin
               state_s = UP;
            end
         end
         DOWN: begin
            if (cnt_value == lo_r + ONE_W) begin
               sweep_s = sweep_inc_s;
               if (sweep_inc_s == n_r) begin
                  done_s  = 1'b1;
                  rst_s   = 1'b1;
                  state_s = IDLE;
               end else begin
                  state_s = UP;
               end
               dir_s = 1'b1;
            end else begin
               state_s = DOWN;
            end
         end
         default: begin
            state_s = IDLE;
            rst_s   = 1'b1;
            dir_s   = 1'b1;
         end
      endcase

      if (state_r != IDLE) begin
         // The counter moves by the dir it saw at this edge.
         exp_s = cnt_dir ? (exp_r + ONE_W) : (exp_r - ONE_W);
         if (stop) begin
            aborted_s = 1'b1;
            done_s    = 1'b0;
            sweep_s   = sweep_cnt;
            rst_s     = 1'b1;
            dir_s     = 1'b1;
            state_s   = IDLE;
         end else if (cnt_value != exp_r) begin
            fault_s   = 1'b1;
            done_s    = 1'b0;
            sweep_s   = sweep_cnt;
            rst_s     = 1'b1;
            dir_s     = 1'b1;
            state_s   = IDLE;
         end else begin
            fault_s   = fault;
         end
      end else begin
         exp_s = exp_s;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         lo_r      <= '0;
         hi_r      <= '0;
         n_r       <= '0;
         exp_r     <= '0;
         sweep_cnt <= '0;
         cnt_rst   <= 1'b1;
         cnt_dir   <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         cfg_err   <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state_r   <= state_s;
         lo_r      <= lo_s;
         hi_r      <= hi_s;
         n_r       <= n_s;
         exp_r     <= exp_s;
         sweep_cnt <= sweep_s;
         cnt_rst   <= rst_s;
         cnt_dir   <= dir_s;
         busy      <= (state_s != IDLE);
         done      <= done_s;
         aborted   <= aborted_s;
         cfg_err   <= cfg_err_s;
         fault     <= fault_s;
      end
   end

endmodule

// File: tb/tb_sweep_ctrl8b.sv
// Directed bench for sweep_ctrl8b with a behavioural up/down counter in the loop;
// expected counts and flags are hand-derived constants.
module tb_sweep_ctrl8b;

   logic       clk, reset, start, stop;
   logic [7:0] lo, hi, n_sweeps, cnt_value, sweep_cnt;
   logic       cnt_rst, cnt_dir, busy, done, aborted, cfg_err, fault;
   logic [7:0] cnt_q, force_val;
   logic       force_en;
   logic [7:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   sweep_ctrl8b #(.WIDTH(8), .SWEEP_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .lo(lo), .hi(hi), .n_sweeps(n_sweeps), .cnt_value(cnt_value),
      .cnt_rst(cnt_rst), .cnt_dir(cnt_dir), .busy(busy), .sweep_cnt(sweep_cnt),
      .done(done), .aborted(aborted), .cfg_err(cfg_err), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter with no enable or load: resets to 0 or steps by dir every edge.
   initial cnt_q = 8'd0;
   always @(posedge clk) begin
      if (cnt_rst !== 1'b0) cnt_q <= 8'd0;
      else if (cnt_dir)     cnt_q <= cnt_q + 8'd1;
      else                  cnt_q <= cnt_q - 8'd1;
   end
   assign cnt_value = force_en ? force_val : cnt_q;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cnt_rst"}, 32'(cnt_rst), 32'd1);
      check({tag, "_cnt_dir"}, 32'(cnt_dir), 32'd1);
      check({tag, "_busy"},    32'(busy),    32'd0);
      check({tag, "_sweep"},   32'(sweep_cnt), 32'd0);
      check({tag, "_done"},    32'(done),    32'd0);
      check({tag, "_aborted"}, 32'(aborted), 32'd0);
      check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
      check({tag, "_fault"},   32'(fault),   32'd0);
   endtask

   task automatic do_start(input logic [7:0] l, input logic [7:0] h, input logic [7:0] n);
      lo = l; hi = h; n_sweeps = n; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      lo = 8'd0; hi = 8'd0; n_sweeps = 8'd0;
      force_en = 1'b0; force_val = 8'd0;
      step();
      step();
      check_reset_vals("reset");
      reset = 1'b0;
      step();

      // 1: two sweeps between 2 and 5, entered through SEEK
      exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2,
                8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2, 8'd0};
      do_start(8'd2, 8'd5, 8'd2);
      check("t1_busy_start", 32'(busy), 32'd1);
      for (int i = 0; i < 16; i++) begin
         check("t1_cnt", 32'(cnt_value), 32'(exp_q[i]));
         if (i == 13) check("t1_no_early_done", 32'(done), 32'd0);
         if (i == 14) begin
            check("t1_done", 32'(done), 32'd1);
            check("t1_sweep", 32'(sweep_cnt), 32'd2);
            check("t1_busy_end", 32'(busy), 32'd0);
         end
         step();
      end
      check("t1_done_pulse", 32'(done), 32'd0);
      check("t1_cnt_rst", 32'(cnt_rst), 32'd1);
      check("t1_fault", 32'(fault), 32'd0);

      // 2: lo=0 skips SEEK
      exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
      do_start(8'd0, 8'd3, 8'd1);
      for (int i = 0; i < 9; i++) begin
         check("t2_cnt", 32'(cnt_value), 32'(exp_q[i]));
         check("t2_done", 32'(done), (i == 6) ? 32'd1 : 32'd0);
         step();
      end
      check("t2_sweep", 32'(sweep_cnt), 32'd1);

      // 3: rejected configurations
      do_start(8'd4, 8'd5, 8'd1);
      check("t3_cfg_err_hi", 32'(cfg_err), 32'd1);
      check("t3_busy_hi", 32'(busy), 32'd0);
      check("t3_rst_hi", 32'(cnt_rst), 32'd1);
      step();
      check("t3_cfg_err_pulse", 32'(cfg_err), 32'd0);
      do_start(8'd4, 8'd7, 8'd0);
      check("t3_cfg_err_n0", 32'(cfg_err), 32'd1);
      check("t3_busy_n0", 32'(busy), 32'd0);
      check("t3_rst_n0", 32'(cnt_rst), 32'd1);
      step();

      // 4: full-range sweep, peak at 255 without wrapping
      do_start(8'd1, 8'd255, 8'd1);
      for (int i = 0; i <= 510; i++) begin
         check("t4_cnt", 32'(cnt_value), (i <= 255) ? 32'(i) : 32'(510 - i));
         if (i == 509) check("t4_done", 32'(done), 32'd1);
         step();
      end
      check("t4_fault", 32'(fault), 32'd0);

      // 5: abort at count 7, then start+stop together
      do_start(8'd0, 8'd10, 8'd3);
      for (int i = 0; i < 7; i++) step();
      check("t5_cnt7", 32'(cnt_value), 32'd7);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t5_aborted", 32'(aborted), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_rst", 32'(cnt_rst), 32'd1);
      check("t5_sweep", 32'(sweep_cnt), 32'd0);
      step();
      check("t5_cnt0", 32'(cnt_value), 32'd0);
      check("t5_abort_pulse", 32'(aborted), 32'd0);
      stop = 1'b1;
      do_start(8'd0, 8'd10, 8'd3);
      stop = 1'b0;
      check("t5_restart_busy", 32'(busy), 32'd1);
      check("t5_restart_abort", 32'(aborted), 32'd0);
      check("t5_restart_cnt", 32'(cnt_value), 32'd0);
      step();
      check("t5_restart_cnt1", 32'(cnt_value), 32'd1);

      // 6: divergence fault, recovery by start, reset mid-UP
      for (int i = 0; i < 5; i++) step();
      check("t6_cnt6", 32'(cnt_value), 32'd6);
      force_val = 8'd9;
      force_en = 1'b1;
      step();
      force_en = 1'b0;
      check("t6_fault", 32'(fault), 32'd1);
      check("t6_rst", 32'(cnt_rst), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_no_done", 32'(done), 32'd0);
      step();
      check("t6_fault_sticky", 32'(fault), 32'd1);
      check("t6_cnt0", 32'(cnt_value), 32'd0);
      do_start(8'd0, 8'd10, 8'd3);
      check("t6_fault_clr", 32'(fault), 32'd0);
      check("t6_busy_again", 32'(busy), 32'd1);
      step();
      step();
      step();
      check("t6_cnt3", 32'(cnt_value), 32'd3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_vals("t6_reset");
      step();
      check("t6_cnt_after_reset", 32'(cnt_value), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
